// File: rtl/counter_load_sched.sv
// counter_load_sched: round-robin scheduler that lends one shared loadable
// up-counter to N_REQ requesters as an interval timer. The owner holds the
// counter for len cycles, then gets a one-cycle done pulse and the pointer
// moves past it. All outputs come straight from flops.
module counter_load_sched #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] len,
  input  logic [WIDTH-1:0]       cnt_val,
  output logic                   cnt_load,
  output logic [WIDTH-1:0]       cnt_data,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t             state_r, state_s;
  logic [IW-1:0]      ptr_r, ptr_s;
  logic [IW-1:0]      owner_r, owner_s;
  logic [WIDTH-1:0]   len_q_r, len_q_s;
  logic [N_REQ-1:0]   grant_r, grant_s;
  logic [N_REQ-1:0]   done_r, done_s;
  logic               cnt_load_r, cnt_load_s;
  logic               busy_r, busy_s;
  logic [IW:0]        pick_s;
  logic [WIDTH-1:0]   len_sel_s;
  logic [IW-1:0]      ptr_after_s;

  // First set request bit at or above the pointer, wrapping; MSB flags a hit.
  // Scanning from the far end down lets the nearest candidate win.
  function automatic logic [IW:0] pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] p);
    logic [IW:0] res;
    int          idx;
    res = {1'b0, {IW{1'b0}}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      else              idx = idx;
      if (r[idx]) res = {1'b1, IW'(idx)};
      else        res = res;
    end
    return res;
  endfunction

  // One-hot vector with bit i set.
  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    logic [N_REQ-1:0] v;
    v    = {N_REQ{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  assign pick_s      = pick(req, ptr_r);
  assign len_sel_s   = len[pick_s[IW-1:0]*WIDTH +: WIDTH];
  assign ptr_after_s = (owner_r == IW'(N_REQ - 1)) ? {IW{1'b0}} : owner_r + IW'(1);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    owner_s    = owner_r;
    len_q_s    = len_q_r;
    grant_s    = grant_r;
    done_s     = {N_REQ{1'b0}};
    cnt_load_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_s[IW]) begin
          state_s    = LOAD;
          owner_s    = pick_s[IW-1:0];
          // A zero length still gets one RUN cycle.
          len_q_s    = (len_sel_s == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : len_sel_s;
          grant_s    = onehot(pick_s[IW-1:0]);
          cnt_load_s = 1'b1;
        end else begin
          state_s = IDLE;
          grant_s = {N_REQ{1'b0}};
        end
      end
      LOAD: begin
        if (!req[owner_r]) begin
          state_s = IDLE;
          grant_s = {N_REQ{1'b0}};
          ptr_s   = ptr_after_s;
        end else begin
          state_s = RUN;
        end
      end
      RUN: begin
        // Abort wins over expiry in the same cycle.
        if (!req[owner_r]) begin
          state_s = IDLE;
          grant_s = {N_REQ{1'b0}};
          ptr_s   = ptr_after_s;
        end else if (cnt_val == len_q_r - {{(WIDTH-1){1'b0}}, 1'b1}) begin
          state_s = DONE;
          grant_s = {N_REQ{1'b0}};
          done_s  = onehot(owner_r);
          ptr_s   = ptr_after_s;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        grant_s = {N_REQ{1'b0}};
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      ptr_r      <= {IW{1'b0}};
      owner_r    <= {IW{1'b0}};
      len_q_r    <= {WIDTH{1'b0}};
      grant_r    <= {N_REQ{1'b0}};
      done_r     <= {N_REQ{1'b0}};
      cnt_load_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      owner_r    <= owner_s;
      len_q_r    <= len_q_s;
      grant_r    <= grant_s;
      done_r     <= done_s;
      cnt_load_r <= cnt_load_s;
      busy_r     <= busy_s;
    end
  end

  assign cnt_load = cnt_load_r;
  assign cnt_data = {WIDTH{1'b0}};
  assign grant    = grant_r;
  assign done     = done_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_counter_load_sched.sv
// Directed bench for counter_load_sched with a behavioural shared counter.
module tb_counter_load_sched;

  localparam int WIDTH = 8;
  localparam int N_REQ = 4;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] len;
  logic [WIDTH-1:0]       cnt_val;
  logic                   cnt_load;
  logic [WIDTH-1:0]       cnt_data;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;

  int total = 0;
  int bad   = 0;

  counter_load_sched #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .cnt_val(cnt_val),
    .cnt_load(cnt_load), .cnt_data(cnt_data), .grant(grant), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared free-running counter, loadable by the scheduler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt_val <= '0;
    else if (cnt_load) cnt_val <= cnt_data;
    else               cnt_val <= cnt_val + 8'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_len(input int i, input logic [WIDTH-1:0] v);
    len[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int gcnt;
    int dcyc;
    int maxc;

    req = '0;
    len = '0;
    rst = 1'b1;
    #2;
    do_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_load", 32'(cnt_load), 32'h0);
    chk("rst_data", 32'(cnt_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // 1) single requester, len 5
    req = 4'b0001; set_len(0, 8'd5);
    tick();
    chk("t1_c1_grant", 32'(grant), 32'h1);
    chk("t1_c1_load", 32'(cnt_load), 32'h1);
    chk("t1_c1_busy", 32'(busy), 32'h1);
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk("t1_run_grant", 32'(grant), 32'h1);
      chk("t1_run_load", 32'(cnt_load), 32'h0);
      chk("t1_run_cnt", 32'(cnt_val), 32'(c - 2));
      chk("t1_run_done", 32'(done), 32'h0);
    end
    tick();
    chk("t1_c7_done", 32'(done), 32'h1);
    chk("t1_c7_grant", 32'(grant), 32'h0);
    chk("t1_c7_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    chk("t1_c8_busy", 32'(busy), 32'h0);
    chk("t1_c8_done", 32'(done), 32'h0);

    // 2) two simultaneous requesters, round-robin fairness
    do_reset();
    req = 4'b0101; set_len(0, 8'd3); set_len(2, 8'd2);
    tick();
    chk("t2_c1_grant", 32'(grant), 32'h1);
    repeat (3) tick();
    chk("t2_c4_cnt", 32'(cnt_val), 32'd2);
    chk("t2_c4_grant", 32'(grant), 32'h1);
    tick();
    chk("t2_c5_done", 32'(done), 32'h1);
    tick();
    chk("t2_c6_busy", 32'(busy), 32'h0);
    chk("t2_c6_grant", 32'(grant), 32'h0);
    tick();
    chk("t2_c7_grant", 32'(grant), 32'h4);
    repeat (2) tick();
    chk("t2_c9_cnt", 32'(cnt_val), 32'd1);
    tick();
    chk("t2_c10_done", 32'(done), 32'h4);
    tick();
    chk("t2_c11_busy", 32'(busy), 32'h0);
    tick();
    chk("t2_c12_regrant", 32'(grant), 32'h1);
    req = 4'b0000;   // abort during LOAD
    tick();
    chk("t2_abort_grant", 32'(grant), 32'h0);
    chk("t2_abort_busy", 32'(busy), 32'h0);
    chk("t2_abort_done", 32'(done), 32'h0);

    // 3) zero length treated as one
    req = 4'b0010; set_len(1, 8'd0);
    tick();
    chk("t3_c1_grant", 32'(grant), 32'h2);
    tick();
    chk("t3_c2_grant", 32'(grant), 32'h2);
    chk("t3_c2_done", 32'(done), 32'h0);
    tick();
    chk("t3_c3_done", 32'(done), 32'h2);
    chk("t3_c3_grant", 32'(grant), 32'h0);
    req = 4'b0000;
    tick();
    chk("t3_c4_busy", 32'(busy), 32'h0);

    // 4) abort mid-RUN, then pointer must sit at 1
    req = 4'b0001; set_len(0, 8'd200);
    tick();
    chk("t4_c1_grant", 32'(grant), 32'h1);
    repeat (51) tick();
    chk("t4_c52_cnt", 32'(cnt_val), 32'd50);
    chk("t4_c52_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    tick();
    chk("t4_abort_grant", 32'(grant), 32'h0);
    chk("t4_abort_done", 32'(done), 32'h0);
    chk("t4_abort_busy", 32'(busy), 32'h0);
    tick();
    chk("t4_nodone", 32'(done), 32'h0);
    req = 4'b0011;
    tick();
    chk("t4_ptr1_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    tick();
    chk("t4_ptr1_abort", 32'(grant), 32'h0);

    // 5) asynchronous reset in the middle of RUN
    req = 4'b0001; set_len(0, 8'd20);
    tick();
    repeat (3) tick();
    chk("t5_pre_grant", 32'(grant), 32'h1);
    #3;
    rst = 1'b0;
    #1;
    chk("t5_async_grant", 32'(grant), 32'h0);
    chk("t5_async_done", 32'(done), 32'h0);
    chk("t5_async_load", 32'(cnt_load), 32'h0);
    chk("t5_async_busy", 32'(busy), 32'h0);
    tick();
    chk("t5_held_grant", 32'(grant), 32'h0);
    chk("t5_held_done", 32'(done), 32'h0);
    req = 4'b1001;
    #2;
    rst = 1'b1;
    tick();
    chk("t5_ptr0_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    tick();
    chk("t5_abort_grant", 32'(grant), 32'h0);

    // 6) maximum length; len change during ownership is ignored
    req = 4'b0001; set_len(0, 8'd255);
    gcnt = 0; dcyc = 0; maxc = 0; k = 0;
    while (k < 400 && dcyc == 0) begin
      tick();
      k++;
      if (k == 10) set_len(0, 8'd3);
      if (grant == 4'b0001) gcnt++;
      if (k >= 2 && grant == 4'b0001 && int'(cnt_val) > maxc) maxc = int'(cnt_val);
      if (done != 4'b0000) begin
        dcyc = k;
        chk("t6_done_bit", 32'(done), 32'h1);
      end
    end
    chk("t6_done_cycle", 32'(dcyc), 32'd257);
    chk("t6_grant_cycles", 32'(gcnt), 32'd256);
    chk("t6_max_cnt", 32'(maxc), 32'd254);
    req = 4'b0000;
    tick();
    chk("t6_idle_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
